// File: rtl/ddr4_cmd_decoder.sv
// DDR4 command-bus decoder: tracks per-bank open/close state and enforces tRCD, tRP and tRRD,
// reporting each accepted or rejected command one cycle after it is sampled.
module ddr4_cmd_decoder #(
  parameter int unsigned BGWIDTH   = 2,
  parameter int unsigned BAWIDTH   = 2,
  parameter int unsigned ADDRWIDTH = 17,
  parameter int unsigned COLWIDTH  = 10,
  parameter int unsigned TRCD      = 16,
  parameter int unsigned TRP       = 16,
  parameter int unsigned TRRD      = 4,
  localparam int unsigned BANKW    = BGWIDTH + BAWIDTH,
  localparam int unsigned NBANKS   = 2 ** BANKW
) (
  input  logic                 ck_t,
  input  logic                 reset_n,
  input  logic                 cke,
  input  logic                 cs_n,
  input  logic                 act_n,
  input  logic [ADDRWIDTH-1:0] A,
  input  logic [BGWIDTH-1:0]   bg,
  input  logic [BAWIDTH-1:0]   ba,
  output logic                 cmd_valid,
  output logic [2:0]           cmd_type,
  output logic [BANKW-1:0]     cmd_bank,
  output logic [ADDRWIDTH-1:0] cmd_row,
  output logic [COLWIDTH-1:0]  cmd_col,
  output logic [NBANKS-1:0]    bank_open,
  output logic                 err_valid,
  output logic [2:0]           err_code
);

  localparam int unsigned TMAX = (TRCD > TRP) ? TRCD : TRP;
  localparam int unsigned CW   = $clog2(TMAX + 1);
  localparam int unsigned GW   = $clog2(TRRD + 1);

  localparam logic [2:0] CmdAct  = 3'd0;
  localparam logic [2:0] CmdRd   = 3'd1;
  localparam logic [2:0] CmdWr   = 3'd2;
  localparam logic [2:0] CmdPre  = 3'd3;
  localparam logic [2:0] CmdPrea = 3'd4;
  localparam logic [2:0] CmdRef  = 3'd5;

  localparam logic [2:0] ErrActBusy    = 3'd1;
  localparam logic [2:0] ErrTrrd       = 3'd2;
  localparam logic [2:0] ErrRwNotOpen  = 3'd3;
  localparam logic [2:0] ErrRefNotIdle = 3'd4;

  typedef enum logic [1:0] {BkIdle, BkOpening, BkActive, BkClosing} bank_st_e;

  bank_st_e             st_q  [NBANKS];
  bank_st_e             st_d  [NBANKS];
  logic [CW-1:0]        cnt_q [NBANKS];
  logic [CW-1:0]        cnt_d [NBANKS];
  logic [ADDRWIDTH-1:0] row_q [NBANKS];
  logic [ADDRWIDTH-1:0] row_d [NBANKS];
  logic [GW-1:0]        gap_q, gap_d;

  logic                 cmd_valid_q, cmd_valid_d;
  logic [2:0]           cmd_type_q, cmd_type_d;
  logic [BANKW-1:0]     cmd_bank_q, cmd_bank_d;
  logic [ADDRWIDTH-1:0] cmd_row_q, cmd_row_d;
  logic [COLWIDTH-1:0]  cmd_col_q, cmd_col_d;
  logic [NBANKS-1:0]    bank_open_q, bank_open_d;
  logic                 err_valid_q, err_valid_d;
  logic [2:0]           err_code_q, err_code_d;

  logic       sel, is_cmd, is_act, is_rd, is_wr, is_pre, is_prea, is_ref;
  logic       all_idle, gap_ok, act_ok, rw_ok, ref_ok;
  logic [2:0] op;
  logic [BANKW-1:0] bank_idx;
  bank_st_e   cur_st;

  assign sel      = cke & ~cs_n;
  assign bank_idx = {bg, ba};
  assign cur_st   = st_q[bank_idx];
  assign op       = A[16:14];
  assign is_act   = sel & ~act_n;
  assign is_cmd   = sel & act_n;
  assign is_rd    = is_cmd & (op == 3'b101);
  assign is_wr    = is_cmd & (op == 3'b100);
  assign is_pre   = is_cmd & (op == 3'b010) & ~A[10];
  assign is_prea  = is_cmd & (op == 3'b010) & A[10];
  assign is_ref   = is_cmd & (op == 3'b001);

  always_comb begin
    all_idle = 1'b1;
    for (int i = 0; i < NBANKS; i++) begin
      if (st_q[i] != BkIdle) all_idle = 1'b0;
    end
  end

  assign gap_ok = (gap_q >= GW'(TRRD));
  assign act_ok = is_act & (cur_st == BkIdle) & gap_ok;
  assign rw_ok  = (is_rd | is_wr) & (cur_st == BkActive);
  assign ref_ok = is_ref & all_idle;

  // Timers run first; an accepted command then overrides its bank's next state.
  always_comb begin
    for (int i = 0; i < NBANKS; i++) begin
      st_d[i]  = st_q[i];
      cnt_d[i] = cnt_q[i];
      row_d[i] = row_q[i];
      case (st_q[i])
        BkOpening: begin
          if (cnt_q[i] <= CW'(1)) begin
            st_d[i]  = BkActive;
            cnt_d[i] = '0;
          end else begin
            cnt_d[i] = cnt_q[i] - CW'(1);
          end
        end
        BkClosing: begin
          if (cnt_q[i] <= CW'(1)) begin
            st_d[i]  = BkIdle;
            cnt_d[i] = '0;
          end else begin
            cnt_d[i] = cnt_q[i] - CW'(1);
          end
        end
        default: ;
      endcase
      if (act_ok && (bank_idx == BANKW'(i))) begin
        row_d[i] = A;
        if (TRCD == 1) begin
          st_d[i]  = BkActive;
          cnt_d[i] = '0;
        end else begin
          st_d[i]  = BkOpening;
          cnt_d[i] = CW'(TRCD - 1);
        end
      end
      if (((is_pre && (bank_idx == BANKW'(i))) || is_prea) &&
          ((st_q[i] == BkOpening) || (st_q[i] == BkActive))) begin
        if (TRP == 1) begin
          st_d[i]  = BkIdle;
          cnt_d[i] = '0;
        end else begin
          st_d[i]  = BkClosing;
          cnt_d[i] = CW'(TRP - 1);
        end
      end
      bank_open_d[i] = (st_d[i] == BkActive);
    end
  end

  always_comb begin
    if (act_ok) begin
      gap_d = GW'(1);
    end else if (!gap_ok) begin
      gap_d = gap_q + GW'(1);
    end else begin
      gap_d = gap_q;
    end
  end

  always_comb begin
    cmd_valid_d = 1'b0;
    cmd_type_d  = '0;
    cmd_bank_d  = '0;
    cmd_row_d   = '0;
    cmd_col_d   = '0;
    err_valid_d = 1'b0;
    err_code_d  = '0;
    if (is_act) begin
      if (act_ok) begin
        cmd_valid_d = 1'b1;
        cmd_type_d  = CmdAct;
        cmd_bank_d  = bank_idx;
        cmd_row_d   = A;
      end else begin
        err_valid_d = 1'b1;
        err_code_d  = (cur_st != BkIdle) ? ErrActBusy : ErrTrrd;
      end
    end else if (is_rd || is_wr) begin
      if (rw_ok) begin
        cmd_valid_d = 1'b1;
        cmd_type_d  = is_rd ? CmdRd : CmdWr;
        cmd_bank_d  = bank_idx;
        cmd_row_d   = row_q[bank_idx];
        cmd_col_d   = A[COLWIDTH-1:0];
      end else begin
        err_valid_d = 1'b1;
        err_code_d  = ErrRwNotOpen;
      end
    end else if (is_pre) begin
      cmd_valid_d = 1'b1;
      cmd_type_d  = CmdPre;
      cmd_bank_d  = bank_idx;
    end else if (is_prea) begin
      cmd_valid_d = 1'b1;
      cmd_type_d  = CmdPrea;
    end else if (is_ref) begin
      if (ref_ok) begin
        cmd_valid_d = 1'b1;
        cmd_type_d  = CmdRef;
        cmd_bank_d  = bank_idx;
      end else begin
        err_valid_d = 1'b1;
        err_code_d  = ErrRefNotIdle;
      end
    end
  end

  always_ff @(posedge ck_t or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < NBANKS; i++) begin
        st_q[i]  <= BkIdle;
        cnt_q[i] <= '0;
        row_q[i] <= '0;
      end
      gap_q       <= GW'(TRRD);
      cmd_valid_q <= 1'b0;
      cmd_type_q  <= '0;
      cmd_bank_q  <= '0;
      cmd_row_q   <= '0;
      cmd_col_q   <= '0;
      bank_open_q <= '0;
      err_valid_q <= 1'b0;
      err_code_q  <= '0;
    end else begin
      for (int i = 0; i < NBANKS; i++) begin
        st_q[i]  <= st_d[i];
        cnt_q[i] <= cnt_d[i];
        row_q[i] <= row_d[i];
      end
      gap_q       <= gap_d;
      cmd_valid_q <= cmd_valid_d;
      cmd_type_q  <= cmd_type_d;
      cmd_bank_q  <= cmd_bank_d;
      cmd_row_q   <= cmd_row_d;
      cmd_col_q   <= cmd_col_d;
      bank_open_q <= bank_open_d;
      err_valid_q <= err_valid_d;
      err_code_q  <= err_code_d;
    end
  end

  assign cmd_valid = cmd_valid_q;
  assign cmd_type  = cmd_type_q;
  assign cmd_bank  = cmd_bank_q;
  assign cmd_row   = cmd_row_q;
  assign cmd_col   = cmd_col_q;
  assign bank_open = bank_open_q;
  assign err_valid = err_valid_q;
  assign err_code  = err_code_q;

endmodule

// File: doc/ddr4_cmd_decoder.md
DDR4_CMD_DECODER -- requirements
Module: ddr4_cmd_decoder

Interface
REQ-001 SHALL have these parameters, one per line: name, default, meaning.
  BGWIDTH, 2, bank-group address width; BANKGROUPS = 2**BGWIDTH.
  BAWIDTH, 2, bank address width; BANKSPERGROUP = 2**BAWIDTH; NBANKS = BANKGROUPS*BANKSPERGROUP.
  ADDRWIDTH, 17, A bus and row width.
  COLWIDTH, 10, column width taken from A[COLWIDTH-1:0].
  TRCD, 16, ACT to RD/WR minimum, in ck_t cycles (>=1).
  TRP, 16, PRE to ACT minimum, in ck_t cycles (>=1).
  TRRD, 4, ACT to ACT minimum across any banks, in ck_t cycles (>=1).
REQ-002 SHALL have these ports, one per line: name direction width meaning.
  ck_t  input  1  only clock; all logic on rising edge.
  reset_n  input  1  asynchronous, active-low reset.
  cke  input  1  clock enable; 0 = command bus ignored.
  cs_n  input  1  chip select, active low.
  act_n  input  1  activate, active low.
  A  input  ADDRWIDTH  row/command/column bus; A[16]=RAS_n, A[15]=CAS_n, A[14]=WE_n, A[10]=AP/all.
  bg  input  BGWIDTH  bank group.
  ba  input  BAWIDTH  bank.
  cmd_valid  output  1  one-cycle pulse: legal command accepted.
  cmd_type  output  3  0 ACT, 1 RD, 2 WR, 3 PRE, 4 PREA, 5 REF.
  cmd_bank  output  BGWIDTH+BAWIDTH  {bg,ba} of accepted command.
  cmd_row  output  ADDRWIDTH  ACT row, or open row of the bank for RD/WR; 0 otherwise.
  cmd_col  output  COLWIDTH  column for RD/WR; 0 otherwise.
  bank_open  output  NBANKS  bit {bg,ba} = 1 when that bank is ACTIVE.
  err_valid  output  1  one-cycle pulse: command rejected.
  err_code  output  3  1 ACT_BUSY, 2 TRRD, 3 RW_NOT_OPEN, 4 REF_NOT_IDLE.

Function
REQ-003 SHALL sample the bus each rising ck_t with cke=1 and cs_n=0; cke=0 or cs_n=1 is a deselect; counters keep running either way.
REQ-004 SHALL decode: act_n=0 -> ACT; act_n=1 with {A16,A15,A14} = 101 RD, 100 WR, 010 PRE (A10=1 -> PREA), 001 REF; all other codes (NOP, MRS, ZQ) ignored with neither pulse.
REQ-005 SHALL register every output; a command sampled at edge n appears at edge n+1 (latency 1); cmd_valid and err_valid never both 1.
REQ-006 SHALL keep per-bank state IDLE, OPENING, ACTIVE, CLOSING, plus stored row and a down-counter of width $clog2(max(TRCD,TRP)+1).
REQ-007 ACT on IDLE bank with TRRD satisfied: accept, store row=A, load TRCD-1, go OPENING (go directly to ACTIVE if TRCD=1).
REQ-008 OPENING decrements each cycle and enters ACTIVE when counter is 0; RD/WR is first legal exactly TRCD cycles after ACT.
REQ-009 PRE on ACTIVE or OPENING bank: accept, load TRP-1, go CLOSING (IDLE if TRP=1); CLOSING goes IDLE at 0, so ACT is legal exactly TRP cycles after PRE.
REQ-010 PRE on IDLE or CLOSING bank: accepted as no-op with cmd_valid=1 and no state or counter change; PREA applies REQ-009 to every bank and is reported with cmd_bank=0.
REQ-011 ACT on a non-IDLE bank SHALL be rejected with err_code ACT_BUSY, which has priority over TRRD.
REQ-012 Global ACT gap counter SHALL saturate at TRRD; ACT fewer than TRRD cycles after the previous accepted ACT SHALL be rejected with TRRD; only accepted ACTs restart the gap.
REQ-013 RD/WR SHALL be accepted only in ACTIVE, with cmd_row = stored row; otherwise rejected with RW_NOT_OPEN; A10 auto-precharge is ignored.
REQ-014 REF SHALL be accepted only when all banks are IDLE; otherwise rejected with REF_NOT_IDLE; there is no refresh timing.
REQ-015 A rejected command SHALL change no state, counter or stored row.
REQ-016 A counter reaching 0 and a command to the same bank on the same edge: the command is checked against the pre-edge state; the transition takes effect next cycle.

Reset
REQ-017 reset_n=0 SHALL immediately force all banks IDLE, counters and rows 0, the ACT gap counter saturated at TRRD (first ACT legal), and all outputs 0.
REQ-018 Reset asserted mid-sequence SHALL discard all state; after release the decoder behaves as from power-up.

Verification
REQ-019 TRRD=1, ACT row 1 to all 16 banks on consecutive cycles, bg/ba walking 0..3 -> 16 ACT pulses, cmd_row=1; bank_open=16'hFFFF TRCD cycles after the last ACT.
REQ-020 ACT bank 0 at edge n, RD col 5 at n+TRCD-1 -> RW_NOT_OPEN; RD at n+TRCD -> cmd_type=1, cmd_col=5, cmd_row equals the ACT row.
REQ-021 TRRD=4, ACT bank 0 at n and bank 1 at n+2 -> second rejected TRRD; ACT bank 1 at n+4 accepted.
REQ-022 Banks 0 and 5 ACTIVE, PREA at m -> cmd_type=4; ACT bank 5 at m+TRP-1 -> ACT_BUSY, at m+TRP accepted; REF while bank 5 open -> REF_NOT_IDLE.
REQ-023 With 4 banks OPENING, pulse reset_n low -> outputs and bank_open 0 immediately; first ACT after release accepted with no TRRD error.
